// File: rtl/conv_window_sequencer_if.sv
// Bundles the sequencer's host, address-generator, PE and write-back signals.
// CONV_SEQ_PERF_EN adds the stall_cnt/win_cnt performance counters.
interface conv_window_sequencer_if #(
  parameter int unsigned NUM_PE = 16
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              seq_err;
  logic              addr_step;
  logic              win_done;
  logic [NUM_PE-1:0] pe_reset;
  logic [NUM_PE-1:0] pe_finish;
  logic              ofm_valid;
  logic              ofm_ready;
  logic [15:0]       ofm_x;
  logic [15:0]       ofm_y;
  logic [7:0]        ofm_cgrp;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       win_cnt;

  modport master (
    input  start, abort, win_done, ofm_ready,
    output busy, done, seq_err, addr_step, pe_reset, pe_finish,
           ofm_valid, ofm_x, ofm_y, ofm_cgrp, stall_cnt, win_cnt
  );
  modport slave (
    output start, abort, win_done, ofm_ready,
    input  busy, done, seq_err, addr_step, pe_reset, pe_finish,
           ofm_valid, ofm_x, ofm_y, ofm_cgrp, stall_cnt, win_cnt
  );
`else
  modport master (
    input  start, abort, win_done, ofm_ready,
    output busy, done, seq_err, addr_step, pe_reset, pe_finish,
           ofm_valid, ofm_x, ofm_y, ofm_cgrp
  );
  modport slave (
    output start, abort, win_done, ofm_ready,
    input  busy, done, seq_err, addr_step, pe_reset, pe_finish,
           ofm_valid, ofm_x, ofm_y, ofm_cgrp
  );
`endif
endinterface

// File: rtl/conv_window_sequencer.sv
// Per-window controller for one convolution layer: clear, accumulate, drain, write back.
// Optional CONV_SEQ_PERF_EN adds stall/window performance counters.
module conv_window_sequencer #(
  parameter int unsigned KERNEL_W = 3,
  parameter int unsigned IFM_C    = 16,
  parameter int unsigned OFM_W    = 54,
  parameter int unsigned OFM_H    = 54,
  parameter int unsigned OFM_C    = 32,
  parameter int unsigned NUM_PE   = 16,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  conv_window_sequencer_if.master   seq_io
);

  localparam int unsigned Beats  = KERNEL_W * KERNEL_W * IFM_C / 4;
  localparam int unsigned Cgrps  = OFM_C / NUM_PE;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned DrainW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam int unsigned XW     = (OFM_W > 1) ? $clog2(OFM_W) : 1;
  localparam int unsigned YW     = (OFM_H > 1) ? $clog2(OFM_H) : 1;
  localparam int unsigned CW     = (Cgrps > 1) ? $clog2(Cgrps) : 1;

  localparam logic [BeatW-1:0]  BeatMax  = BeatW'(Beats - 1);
  localparam logic [DrainW-1:0] DrainMax = DrainW'(RD_LAT);
  localparam logic [XW-1:0]     XMax     = XW'(OFM_W - 1);
  localparam logic [YW-1:0]     YMax     = YW'(OFM_H - 1);
  localparam logic [CW-1:0]     CMax     = CW'(Cgrps - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StAccum, StDrain, StWrite, StNext, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     cgrp_q, cgrp_d;
  logic              err_q, err_d;

  logic last_beat, last_win, xfer, launch;

  assign last_beat = (state_q == StAccum) && (beat_q == BeatMax);
  assign last_win  = (x_q == XMax) && (y_q == YMax) && (cgrp_q == CMax);
  assign xfer      = (state_q == StWrite) && seq_io.ofm_ready && !seq_io.abort;
  assign launch    = (state_q == StIdle) && seq_io.start && !seq_io.abort;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    x_d     = x_q;
    y_d     = y_q;
    cgrp_d  = cgrp_q;
    // The address generator must flag window end exactly on the final beat.
    err_d   = err_q | (seq_io.win_done != last_beat);

    unique case (state_q)
      StIdle: begin
        if (seq_io.start) begin
          state_d = StClear;
          x_d     = '0;
          y_d     = '0;
          cgrp_d  = '0;
          err_d   = 1'b0;
        end
      end
      StClear: begin
        state_d = StAccum;
        beat_d  = '0;
      end
      StAccum: begin
        if (beat_q == BeatMax) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainMax) state_d = StWrite;
        else                     drain_d = drain_q + 1'b1;
      end
      StWrite: begin
        if (seq_io.ofm_ready) state_d = StNext;
      end
      StNext: begin
        state_d = last_win ? StDone : StClear;
        if (x_q == XMax) begin
          x_d = '0;
          if (y_q == YMax) begin
            y_d    = '0;
            cgrp_d = (cgrp_q == CMax) ? '0 : cgrp_q + 1'b1;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (seq_io.abort) begin
      state_d = StIdle;
      beat_d  = '0;
      drain_d = '0;
      x_d     = '0;
      y_d     = '0;
      cgrp_d  = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      drain_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cgrp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cgrp_q  <= cgrp_d;
      err_q   <= err_d;
    end
  end

  assign seq_io.busy      = (state_q != StIdle);
  assign seq_io.done      = (state_q == StDone);
  assign seq_io.addr_step = (state_q == StAccum);
  assign seq_io.pe_reset  = {NUM_PE{(state_q == StIdle) || (state_q == StClear)}};
  assign seq_io.pe_finish = {NUM_PE{(state_q == StDrain) && (drain_q == DrainMax)}};
  assign seq_io.ofm_valid = (state_q == StWrite);
  assign seq_io.ofm_x     = 16'(x_q);
  assign seq_io.ofm_y     = 16'(y_q);
  assign seq_io.ofm_cgrp  = 8'(cgrp_q);
  assign seq_io.seq_err   = err_q;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] win_q, win_d;

  always_comb begin
    stall_d = stall_q;
    win_d   = win_q;
    if (launch) begin
      stall_d = '0;
      win_d   = '0;
    end else begin
      if ((state_q == StWrite) && !seq_io.ofm_ready && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
      if (xfer && (win_q != '1)) win_d = win_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      win_q   <= '0;
    end else begin
      stall_q <= stall_d;
      win_q   <= win_d;
    end
  end

  assign seq_io.stall_cnt = stall_q;
  assign seq_io.win_cnt   = win_q;
`else
  logic unused_launch;
  logic unused_xfer;
  assign unused_launch = launch;
  assign unused_xfer   = xfer;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized self-checking bench for conv_window_sequencer on a 2x2x2-window layer,
// checked against a window-order list and a phase timeline built from the layer rules.
module tb_conv_window_sequencer;

  localparam int KW    = 3;
  localparam int IC    = 16;
  localparam int OW    = 2;
  localparam int OH    = 2;
  localparam int OC    = 32;
  localparam int NP    = 16;
  localparam int RL    = 1;
  localparam int Beats = KW * KW * IC / 4;
  localparam int Cgrps = OC / NP;
  localparam int Wins  = OW * OH * Cgrps;

  localparam logic [NP-1:0] Ones  = '1;
  localparam logic [NP-1:0] Zeros = '0;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  conv_window_sequencer_if #(.NUM_PE(NP)) bus ();

  conv_window_sequencer #(
    .KERNEL_W (KW),
    .IFM_C    (IC),
    .OFM_W    (OW),
    .OFM_H    (OH),
    .OFM_C    (OC),
    .NUM_PE   (NP),
    .RD_LAT   (RL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .seq_io  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int wx[Wins];
  int wy[Wins];
  int wc[Wins];
  bit exp_err;
  int exp_stall;
  int exp_wins;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
    check_eq({tag, "_done"}, bus.done, 1'b0);
    check_eq({tag, "_step"}, bus.addr_step, 1'b0);
    check_eq({tag, "_valid"}, bus.ofm_valid, 1'b0);
    check_eq({tag, "_pe_reset"}, bus.pe_reset, Ones);
    check_eq({tag, "_pe_finish"}, bus.pe_finish, Zeros);
    check_eq({tag, "_xyc"}, {bus.ofm_x, bus.ofm_y, bus.ofm_cgrp}, 40'd0);
  endtask

  // Entered at the falling edge where the DUT sits in its clear cycle.
  task automatic do_window(input int idx, input int stall, input int wd_beat,
                           input int abort_beat, input int start_beat, output bit aborted);
    logic [NP-1:0] exp_fin;
    aborted = 1'b0;
    check_eq("clr_pe_reset", bus.pe_reset, Ones);
    check_eq("clr_busy", bus.busy, 1'b1);
    check_eq("clr_step", bus.addr_step, 1'b0);
    check_eq("clr_valid", bus.ofm_valid, 1'b0);
    for (int b = 0; b < Beats; b++) begin
      @(negedge clk);
      check_eq("acc_step", bus.addr_step, 1'b1);
      check_eq("acc_pe_reset", bus.pe_reset, Zeros);
      bus.win_done = (b == wd_beat);
      bus.start    = (b == start_beat);
      if (b == abort_beat) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.start    = 1'b0;
        bus.win_done = 1'b0;
        aborted      = 1'b1;
        return;
      end
    end
    if (wd_beat != Beats - 1) exp_err = 1'b1;
    for (int d = 0; d <= RL; d++) begin
      @(negedge clk);
      bus.win_done = 1'b0;
      bus.start    = 1'b0;
      exp_fin = (d == RL) ? Ones : Zeros;
      check_eq("drn_step", bus.addr_step, 1'b0);
      check_eq("drn_finish", bus.pe_finish, exp_fin);
      check_eq("drn_valid", bus.ofm_valid, 1'b0);
      if (d == RL) bus.ofm_ready = (stall == 0);
    end
    @(negedge clk);
    check_eq("wr_valid", bus.ofm_valid, 1'b1);
    check_eq("wr_finish", bus.pe_finish, Zeros);
    check_eq("wr_x", bus.ofm_x, 64'(wx[idx]));
    check_eq("wr_y", bus.ofm_y, 64'(wy[idx]));
    check_eq("wr_cgrp", bus.ofm_cgrp, 64'(wc[idx]));
    check_eq("wr_err", bus.seq_err, exp_err);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stl_valid", bus.ofm_valid, 1'b1);
      check_eq("stl_step", bus.addr_step, 1'b0);
      check_eq("stl_xyc", {bus.ofm_x, bus.ofm_y, bus.ofm_cgrp},
               {16'(wx[idx]), 16'(wy[idx]), 8'(wc[idx])});
      if (s == stall - 1) bus.ofm_ready = 1'b1;
    end
    exp_stall += stall;
    exp_wins++;
    @(negedge clk);
    check_eq("nxt_valid", bus.ofm_valid, 1'b0);
    check_eq("nxt_busy", bus.busy, 1'b1);
    check_eq("nxt_step", bus.addr_step, 1'b0);
  endtask

  task automatic check_idle_after_abort(input string tag);
    check_reset_vals(tag);
    check_eq({tag, "_err_hold"}, bus.seq_err, exp_err);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq({tag, "_stay_idle"}, bus.busy, 1'b0);
      check_eq({tag, "_no_done"}, bus.done, 1'b0);
    end
  endtask

  // Runs one layer from IDLE; -1 disables a given event.
  task automatic run_layer(input bit rnd_stall, input int stall_win, input int stall_len,
                           input int err_win, input int err_beat,
                           input int start_win, input int start_beat,
                           input int abort_win, input int abort_beat, output bit aborted);
    int st;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_err   = 1'b0;
    exp_stall = 0;
    exp_wins  = 0;
    check_eq("start_err_clr", bus.seq_err, 1'b0);
    aborted = 1'b0;
    for (int i = 0; i < Wins; i++) begin
      if (i == stall_win)                          st = stall_len;
      else if (rnd_stall && $urandom_range(0, 1))  st = int'($urandom_range(1, 4));
      else                                         st = 0;
      do_window(i, st, (i == err_win) ? err_beat : Beats - 1,
                (i == abort_win) ? abort_beat : -1,
                (i == start_win) ? start_beat : -1, aborted);
      if (aborted) return;
      @(negedge clk);
    end
    check_eq("done_pulse", bus.done, 1'b1);
    check_eq("done_busy", bus.busy, 1'b1);
    @(negedge clk);
    check_eq("post_done", bus.done, 1'b0);
    check_eq("post_busy", bus.busy, 1'b0);
    check_eq("post_pe_reset", bus.pe_reset, Ones);
    check_eq("post_err", bus.seq_err, exp_err);
`ifdef CONV_SEQ_PERF_EN
    check_eq("stall_cnt", bus.stall_cnt, 64'(exp_stall));
    check_eq("win_cnt", bus.win_cnt, 64'(exp_wins));
    repeat (4) @(negedge clk);
    check_eq("stall_cnt_hold", bus.stall_cnt, 64'(exp_stall));
    check_eq("win_cnt_hold", bus.win_cnt, 64'(exp_wins));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  initial begin
    bit ab;
    int k;
    for (int c = 0; c < Cgrps; c++)
      for (int y = 0; y < OH; y++)
        for (int x = 0; x < OW; x++) begin
          k = c * OW * OH + y * OW + x;
          wx[k] = x;
          wy[k] = y;
          wc[k] = c;
        end

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.win_done  = 1'b0;
    bus.ofm_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check_eq("rst_err", bus.seq_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // Clean layer with a 10-cycle write stall on window 3.
    run_layer(1'b0, 3, 10, -1, 0, -1, 0, -1, 0, ab);
    check_eq("a_not_aborted", ab, 1'b0);

    // Early win_done on window 2, stray start on window 1, random stalls.
    run_layer(1'b1, -1, 0, 2, 20, 1, int'($urandom_range(0, Beats - 1)), -1, 0, ab);
    check_eq("b_err_sticky", bus.seq_err, 1'b1);

    // Bad win_done in window 0, then abort mid-accumulate of window 5.
    run_layer(1'b1, -1, 0, 0, int'($urandom_range(0, Beats - 2)), -1, 0,
              5, int'($urandom_range(0, Beats - 1)), ab);
    check_eq("c_aborted", ab, 1'b1);
    check_idle_after_abort("c_abort");

    // Reset during a stalled write.
    bus.ofm_ready = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < Beats + RL + 2; i++) begin
      @(negedge clk);
      bus.win_done = (i == Beats - 1);
    end
    check_eq("d_in_write", bus.ofm_valid, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("d_reset");
    check_eq("d_reset_err", bus.seq_err, 1'b0);
    reset_n       = 1'b1;
    bus.ofm_ready = 1'b1;
    @(negedge clk);

    // Start coincident with abort in window 2's accumulate: abort wins.
    k = int'($urandom_range(0, Beats - 1));
    run_layer(1'b0, -1, 0, -1, 0, 2, k, 2, k, ab);
    check_eq("e_aborted", ab, 1'b1);
    check_idle_after_abort("e_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
